// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle MIPS core: reset sequencing, clock enable, run/retire counters, halt and timeout detection.
// Latency: RUN begins RESET_CYCLES+1 cycles after start; done/timeout rise one cycle after the deciding RUN edge.
// Backpressure: none; start is honoured only in IDLE/HALTED/TIMEOUT and ignored in RESET/RUN.
module cpu_run_ctrl #(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 5,
  parameter int HALT_REPEAT  = 3,
  parameter int MAX_CYCLES   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic             retire,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int MC_W = $clog2(HALT_REPEAT + 1);

  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RESET_CYCLES - 1);
  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
    S_HALTED  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [RC_W-1:0]   rst_cnt;
  logic [MC_W-1:0]   match_cnt;
  logic [PC_W-1:0]   pc_q;
  logic              pc_q_vld;

  logic              is_match;
  logic              halt_hit;
  logic              limit_hit;
  logic              accept_start;
  logic              enter_run;

  // Halt/timeout qualifiers; only consumed while in RUN. Halt outranks the cycle limit.
  assign is_match     = pc_valid && pc_q_vld && (pc == pc_q);
  assign halt_hit     = is_match && (match_cnt == MC_LAST);
  assign limit_hit    = (cycle_cnt == CYC_LAST) && !halt_hit;
  assign accept_start = start && (cur_state inside {S_IDLE, S_HALTED, S_TIMEOUT});
  assign enter_run    = (cur_state == S_RESET) && (rst_cnt == '0);

  // State register; rst wins over every transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state selection.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:    if (start) nxt_state = S_RESET;
      S_RESET:   if (rst_cnt == '0) nxt_state = S_RUN;
      S_RUN: begin
        if (halt_hit) begin
          nxt_state = S_HALTED;
        end else if (limit_hit) begin
          nxt_state = S_TIMEOUT;
        end
      end
      S_HALTED,
      S_TIMEOUT: if (start) nxt_state = S_RESET;
      default:   nxt_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state; CPU held in reset before RUN, frozen (not reset) after it.
  always_comb begin
    cpu_rst = 1'b0;
    cpu_en  = 1'b0;
    running = 1'b0;
    state   = cur_state;
    case (cur_state)
      S_IDLE, S_RESET: cpu_rst = 1'b1;
      S_RUN: begin
        cpu_en  = 1'b1;
        running = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset-length counter: loaded when a run is requested, counts down while in RESET.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rst_cnt <= '0;
    end else if (accept_start) begin
      rst_cnt <= RC_LOAD;
    end else if ((cur_state == S_RESET) && (rst_cnt != '0)) begin
      rst_cnt <= rst_cnt - 1'b1;
    end
  end

  // Run counters, PC history, match streak and sticky status; cleared on RUN entry, frozen outside RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      match_cnt   <= '0;
      pc_q        <= '0;
      pc_q_vld    <= 1'b0;
    end else if (enter_run) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      match_cnt   <= '0;
      pc_q_vld    <= 1'b0;
    end else if (cur_state == S_RUN) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) begin
        retired_cnt <= retired_cnt + 1'b1;
      end
      if (pc_valid) begin
        pc_q     <= pc;
        pc_q_vld <= 1'b1;
      end
      match_cnt <= is_match ? (match_cnt + 1'b1) : '0;
      if (halt_hit) begin
        done <= 1'b1;
      end else if (limit_hit) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios with literal expectations plus randomized traffic.
// Outputs compared against a behavioural model on every falling edge once the first reset has been seen.
// Inputs change 1 time unit after each rising edge; directed literal checks are taken at the same point.
module tb_cpu_run_ctrl;

  localparam int RC = 5;
  localparam int HR = 3;
  localparam int MC = 16;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        start    = 1'b0;
  logic        pc_valid = 1'b0;
  logic        retire   = 1'b0;
  logic [31:0] pc       = '0;

  logic        cpu_rst, cpu_en, running, done, timeout;
  logic [31:0] cycle_cnt, retired_cnt;
  logic [2:0]  state;

  cpu_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RESET_CYCLES(RC), .HALT_REPEAT(HR), .MAX_CYCLES(MC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid), .retire(retire),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase numbers follow the state output encoding: 0 idle, 1 reset, 2 run, 3 halted, 4 timeout.
  bit          m_known   = 1'b0;
  int          m_state   = 0;
  int          m_left    = 0;   // reset cycles still to spend
  int          m_cycles  = 0;   // completed run cycles
  int          m_repeats = 0;   // consecutive cycles whose valid pc equals the previous valid pc
  logic [31:0] m_retired = '0;
  logic [31:0] m_last    = '0;
  bit          m_last_ok = 1'b0;
  bit          m_done    = 1'b0;
  bit          m_to      = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_known = 1'b1; m_state = 0; m_cycles = 0; m_retired = '0;
      m_done = 1'b0; m_to = 1'b0; m_last_ok = 1'b0; m_repeats = 0;
    end else if (m_known) begin
      case (m_state)
        0: if (start) begin m_state = 1; m_left = RC; end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_state = 2; m_cycles = 0; m_retired = '0; m_done = 1'b0; m_to = 1'b0;
            m_repeats = 0; m_last_ok = 1'b0;
          end
        end
        2: begin
          m_cycles++;
          if (retire) m_retired++;
          if (pc_valid && m_last_ok && pc == m_last) m_repeats++;
          else m_repeats = 0;
          if (pc_valid) begin m_last = pc; m_last_ok = 1'b1; end
          if (m_repeats == HR) begin
            m_state = 3; m_done = 1'b1;
          end else if (m_cycles == MC) begin
            m_state = 4; m_to = 1'b1;
          end
        end
        default: if (start) begin m_state = 1; m_left = RC; end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_known) begin
      chk("state",       state,       m_state);
      chk("cpu_rst",     cpu_rst,     (m_state <= 1));
      chk("cpu_en",      cpu_en,      (m_state == 2));
      chk("running",     running,     (m_state == 2));
      chk("done",        done,        m_done);
      chk("timeout",     timeout,     m_to);
      chk("cycle_cnt",   cycle_cnt,   m_cycles);
      chk("retired_cnt", retired_cnt, m_retired);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit s, input bit pv, input logic [31:0] p, input bit r);
    start = s; pc_valid = pv; pc = p; retire = r;
    @(posedge clk); #1;
  endtask

  // Pulse start and wait (bounded) for RUN, counting cycles with cpu_rst high.
  task automatic begin_run(output int n_rst);
    n_rst = 0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20 && !running; i++) begin
      if (cpu_rst) n_rst++;
      cyc(1'b0, 1'b0, '0, 1'b0);
    end
    chk("run_entry", running, 1);
  endtask

  initial begin
    int n;

    // Reset and start sequencing
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    chk("rst_state",   state, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_en",  cpu_en, 0);
    chk("rst_cycles",  cycle_cnt, 0);
    chk("rst_done",    done, 0);
    rst = 1'b1;
    cyc(0, 0, '0, 0);
    begin_run(n);
    chk("reset_len",      n, 5);
    chk("entry_cycles",   cycle_cnt, 0);
    chk("entry_retired",  retired_cnt, 0);
    chk("model_entry",    m_state, 2);

    // Halt on self-loop
    cyc(0, 1, 32'h3000, 1);
    cyc(0, 1, 32'h3004, 0);
    repeat (3) cyc(0, 1, 32'h3008, 0);
    chk("halt_not_yet", done, 0);
    cyc(0, 1, 32'h3008, 0);
    chk("halt_done",    done, 1);
    chk("halt_cycles",  cycle_cnt, 6);
    chk("halt_cpu_en",  cpu_en, 0);
    chk("halt_state",   state, 3);
    chk("model_halt",   m_cycles, 6);
    repeat (3) cyc(0, 1, 32'h3008, 1);
    chk("halt_frozen_cyc", cycle_cnt, 6);
    chk("halt_frozen_ret", retired_cnt, 1);

    // Broken self-loop
    begin_run(n);
    repeat (3) cyc(0, 1, 32'h3008, 0);
    cyc(0, 1, 32'h300c, 0);
    repeat (3) cyc(0, 1, 32'h3008, 0);
    chk("broken_no_halt", done, 0);
    cyc(0, 1, 32'h3008, 0);
    chk("broken_halt",    done, 1);
    chk("broken_cycles",  cycle_cnt, 8);

    // pc_valid gap clears the streak
    begin_run(n);
    repeat (3) cyc(0, 1, 32'h3008, 0);
    cyc(0, 0, 32'h3008, 0);
    repeat (2) cyc(0, 1, 32'h3008, 0);
    chk("gap_no_halt", done, 0);
    cyc(0, 1, 32'h3008, 0);
    chk("gap_halt",    done, 1);
    chk("gap_cycles",  cycle_cnt, 7);

    // Timeout with incrementing PC
    begin_run(n);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (cpu_en) n++;
      cyc(0, 1, 32'h100 + 32'(4 * i), (i % 2) == 0);
    end
    chk("to_en_cycles", n, 16);
    chk("to_flag",      timeout, 1);
    chk("to_done",      done, 0);
    chk("to_cycles",    cycle_cnt, 16);
    chk("to_retired",   retired_cnt, 8);
    chk("to_state",     state, 4);
    chk("to_cpu_en",    cpu_en, 0);

    // Tie: third match on the last allowed RUN cycle
    begin_run(n);
    for (int i = 0; i < 12; i++) cyc(0, 1, 32'h200 + 32'(4 * i), 0);
    repeat (4) cyc(0, 1, 32'h5000, 0);
    chk("tie_done",    done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_cycles",  cycle_cnt, 16);
    chk("tie_state",   state, 3);

    // Mid-run reset, start ignored during RUN
    begin_run(n);
    for (int i = 0; i < 6; i++) cyc(i == 2, 1, 32'h400 + 32'(4 * i), 1);
    chk("midrun_running", running, 1);
    chk("midrun_cycles",  cycle_cnt, 6);
    rst = 1'b0;
    cyc(0, 1, 32'h418, 1);
    chk("midrun_state",   state, 0);
    chk("midrun_cyc0",    cycle_cnt, 0);
    chk("midrun_ret0",    retired_cnt, 0);
    chk("midrun_cpu_rst", cpu_rst, 1);
    rst = 1'b1;
    begin_run(n);
    chk("fresh_reset_len", n, 5);
    chk("fresh_cycles",    cycle_cnt, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) != 0);
      start    = ($urandom_range(0, 9) == 0);
      pc_valid = ($urandom_range(0, 4) != 0);
      pc       = 32'($urandom_range(0, 1)) << 2;
      retire   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    repeat (3) cyc(0, 0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run controller for the single-cycle MIPS core. It sequences CPU reset and gates CPU execution through a clock enable. It counts run cycles and retired instructions, detects program halt as a self-loop on the PC, and aborts runaway programs with a cycle-limit timeout. It sits between the top-level clk/rst and the CPU core, and is used both in simulation harnesses and on-board bring-up.

## Interface
Parameters:
- PC_W, 32, PC width.
- CNT_W, 32, width of cycle and retired counters.
- RESET_CYCLES, 5, cycles cpu_rst is held in the RESET state (≥1).
- HALT_REPEAT, 3, consecutive matching-PC cycles that declare a halt (≥1).
- MAX_CYCLES, 1000, RUN-cycle limit before timeout (1 ≤ MAX_CYCLES < 2^CNT_W).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a run.
- pc  in  PC_W  current CPU PC.
- pc_valid  in  1  pc is meaningful this cycle.
- retire  in  1  CPU committed one instruction this cycle.
- cpu_rst  out  1  active-high reset to the CPU.
- cpu_en  out  1  CPU clock enable; high only in RUN.
- running  out  1  state == RUN.
- done  out  1  sticky; halt detected.
- timeout  out  1  sticky; cycle limit reached.
- cycle_cnt  out  CNT_W  RUN cycles elapsed.
- retired_cnt  out  CNT_W  instructions retired during RUN.
- state  out  3  IDLE=0, RESET=1, RUN=2, HALTED=3, TIMEOUT=4.

## Operation
- The FSM has five states: IDLE, RESET, RUN, HALTED, TIMEOUT. All outputs are registered or decoded from state.
- rst low: at the next edge, state=IDLE, cpu_rst=1, cpu_en=0, done=0, timeout=0, both counters 0, match counter 0, pc_q valid flag cleared. Reset takes priority over every other event, including a reset asserted in the middle of a run.
- IDLE: cpu_rst=1. start=1 → RESET; the reset counter is loaded with RESET_CYCLES-1.
- RESET: cpu_rst=1 and cpu_en=0. The reset counter decrements each cycle. When it reaches 0 → RUN, and cycle_cnt, retired_cnt, done, timeout and the match counter are all cleared.
- RUN: cpu_rst=0, cpu_en=1.
  - cycle_cnt increments every cycle.
  - retired_cnt increments when retire=1. It wraps modulo 2^CNT_W.
- Halt detect, evaluated in RUN only:
  - pc_q captures pc on every pc_valid cycle.
  - A cycle is a match when pc_valid=1, pc_q is valid and pc==pc_q.
  - On a match the match counter increments; on any non-match cycle it clears to 0.
  - When a match occurs with the match counter at HALT_REPEAT-1 → HALTED with done=1.
- Timeout: in RUN, when cycle_cnt==MAX_CYCLES-1 and the halt condition is not met this cycle → TIMEOUT with timeout=1. cycle_cnt ends at exactly MAX_CYCLES.
- Simultaneous halt and timeout in the same cycle: halt wins. done=1, timeout=0.
- HALTED and TIMEOUT:
  - cpu_rst=0, cpu_en=0, so CPU architectural state is frozen for inspection.
  - Counters are frozen; done/timeout are sticky.
  - start=1 → RESET, beginning a fresh run.
- start in RESET or RUN is ignored.
- pc_valid=0 in RUN: the cycle is a non-match and pc_q is held.

## Timing
- start sampled at edge N (IDLE). cpu_rst stays 1 for cycles N+1 through N+RESET_CYCLES. state=RUN and cpu_en=1 from N+RESET_CYCLES+1.
- cycle_cnt reads k after k RUN cycles have completed.
- Halt latency: done rises one cycle after the edge that samples the HALT_REPEAT-th consecutive match. cpu_en falls in that same cycle.
- Timeout: exactly MAX_CYCLES cycles have cpu_en=1. timeout rises in the following cycle.
- The first RUN cycle can never match, because pc_q is not yet valid.
- Any single-cycle rst=0 pulse returns the block to IDLE at the next edge, regardless of state.

## Test plan
- Reset/start sequencing, RESET_CYCLES=5: rst=0 for 2 cycles, then start pulse → cpu_rst high for exactly 5 cycles after start, running=1 on the 6th, all counters 0 on RUN entry.
- Halt, HALT_REPEAT=3: PC sequence 0x3000, 0x3004, 0x3008, then 0x3008 held with pc_valid=1 → done=1 one cycle after the 3rd repeat; cycle_cnt=6; cpu_en=0; counters frozen.
- Broken self-loop: 0x3008 ×3 (2 matches), then 0x300c, then 0x3008 ×3 → no halt until the second group's 3rd match; also show that a pc_valid=0 gap clears the match count.
- Timeout, MAX_CYCLES=16, incrementing PC → timeout=1, cycle_cnt=16, done=0; retire every other cycle → retired_cnt=8.
- Tie: MAX_CYCLES=16 with the 3rd match landing on RUN cycle 16 → done=1, timeout=0.
- Mid-run rst=0 at cycle 7, then start again → state=IDLE next edge, counters 0, then a clean fresh run; start pulses during RUN have no effect.
